// File: rtl/cpu_run_ctl_pkg.sv
// Shared state encodings, probe select codes and default widths for the run controller.
package cpu_run_ctl_pkg;

  localparam int DM_ADDR_BIT   = 10;
  localparam int RUNCTL_ST_BIT = 2;
  localparam int PROBE_SEL_BIT = 3;

  typedef enum logic [RUNCTL_ST_BIT-1:0] {
    RUNCTL_ST_IDLE   = 2'd0,
    RUNCTL_ST_RUN    = 2'd1,
    RUNCTL_ST_STEP   = 2'd2,
    RUNCTL_ST_HALTED = 2'd3
  } runctl_st_t;

  typedef enum logic [PROBE_SEL_BIT-1:0] {
    PROBE_SEL_DISPLAY    = 3'd0,
    PROBE_SEL_PC         = 3'd1,
    PROBE_SEL_REGFILE    = 3'd2,
    PROBE_SEL_DATAMEM    = 3'd3,
    PROBE_SEL_INST_CNT   = 3'd4,
    PROBE_SEL_JUMP_CNT   = 3'd5,
    PROBE_SEL_BRANCH_CNT = 3'd6,
    PROBE_SEL_TAKEN_CNT  = 3'd7
  } probe_sel_t;

endpackage

// File: rtl/cpu_run_ctl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// One clk latency from inc/clr to cnt, never stalls.
module sat_counter #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + Width'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctl.sv
// Run/step/pause controller for the CPU with retirement statistics and a registered debug probe.
// cpu_en is combinational from state; probe_data lags its select/sources by one clk.
module cpu_run_ctl
  import cpu_run_ctl_pkg::*;
#(
  parameter int DmAddrBit = DM_ADDR_BIT,
  parameter int CntBit    = 32,
  parameter int RunDiv    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 pause_req,
  input  logic                 clr_cnt,
  input  logic [2:0]           probe_sel,
  input  logic [7:0]           probe_idx,
  input  logic                 cpu_halt,
  input  logic                 cpu_is_jump,
  input  logic                 cpu_is_branch,
  input  logic                 cpu_branched,
  input  logic [31:0]          cpu_pc_dbg,
  input  logic [31:0]          cpu_regfile_data_dbg,
  input  logic [31:0]          cpu_datamem_data_dbg,
  input  logic [31:0]          cpu_display,
  output logic                 cpu_en,
  output logic [4:0]           regfile_req_dbg,
  output logic [DmAddrBit-1:0] datamem_addr_dbg,
  output logic [31:0]          probe_data,
  output logic [1:0]           state_dbg
);

  localparam int                DivBit = (RunDiv > 0) ? $clog2(RunDiv + 1) : 1;
  localparam logic [DivBit-1:0] DivMax = DivBit'(RunDiv);

  runctl_st_t        state;
  runctl_st_t        state_nxt;
  logic [DivBit-1:0] div;
  logic [CntBit-1:0] inst_cnt;
  logic [CntBit-1:0] jump_cnt;
  logic [CntBit-1:0] branch_cnt;
  logic [CntBit-1:0] taken_cnt;
  logic [31:0]       probe_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUNCTL_ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUNCTL_ST_IDLE: begin
        if (cpu_halt)      state_nxt = RUNCTL_ST_HALTED;
        else if (run_req)  state_nxt = RUNCTL_ST_RUN;
        else if (step_req) state_nxt = RUNCTL_ST_STEP;
      end
      RUNCTL_ST_RUN: begin
        if (cpu_halt)       state_nxt = RUNCTL_ST_HALTED;
        else if (pause_req) state_nxt = RUNCTL_ST_IDLE;
      end
      RUNCTL_ST_STEP:   state_nxt = cpu_halt ? RUNCTL_ST_HALTED : RUNCTL_ST_IDLE;
      RUNCTL_ST_HALTED: state_nxt = RUNCTL_ST_HALTED;
    endcase
  end

  always_comb begin
    cpu_en    = !rst && !cpu_halt &&
                ((state == RUNCTL_ST_STEP) || ((state == RUNCTL_ST_RUN) && (div == '0)));
    state_dbg = state;
  end

  // Divider only free-runs while staying in RUN, so every RUN entry starts with an enabled clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if ((state == RUNCTL_ST_RUN) && (state_nxt == RUNCTL_ST_RUN)) begin
      div <= (div == DivMax) ? '0 : div + DivBit'(1);
    end else begin
      div <= '0;
    end
  end

  sat_counter #(.Width(CntBit)) u_inst_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .inc(cpu_en), .cnt(inst_cnt));
  sat_counter #(.Width(CntBit)) u_jump_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .inc(cpu_en && cpu_is_jump), .cnt(jump_cnt));
  sat_counter #(.Width(CntBit)) u_branch_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .inc(cpu_en && cpu_is_branch), .cnt(branch_cnt));
  sat_counter #(.Width(CntBit)) u_taken_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .inc(cpu_en && cpu_branched), .cnt(taken_cnt));

  assign regfile_req_dbg = probe_idx[4:0];

  generate
    if (DmAddrBit > 8) begin : g_dm_wide
      assign datamem_addr_dbg = {{(DmAddrBit-8){1'b0}}, probe_idx};
    end else begin : g_dm_narrow
      assign datamem_addr_dbg = probe_idx[DmAddrBit-1:0];
    end
  endgenerate

  always_comb begin
    probe_nxt = '0;
    case (probe_sel_t'(probe_sel))
      PROBE_SEL_DISPLAY:    probe_nxt = cpu_display;
      PROBE_SEL_PC:         probe_nxt = cpu_pc_dbg;
      PROBE_SEL_REGFILE:    probe_nxt = cpu_regfile_data_dbg;
      PROBE_SEL_DATAMEM:    probe_nxt = cpu_datamem_data_dbg;
      PROBE_SEL_INST_CNT:   probe_nxt = 32'(inst_cnt);
      PROBE_SEL_JUMP_CNT:   probe_nxt = 32'(jump_cnt);
      PROBE_SEL_BRANCH_CNT: probe_nxt = 32'(branch_cnt);
      PROBE_SEL_TAKEN_CNT:  probe_nxt = 32'(taken_cnt);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) probe_data <= '0;
    else     probe_data <= probe_nxt;
  end

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Self-checking bench for cpu_run_ctl: cycle model plus probe scoreboard, table-driven probe mux vectors.
module tb_cpu_run_ctl;
  import cpu_run_ctl_pkg::*;

  localparam int RUN_DIV = 3;
  localparam int CNT_BIT = 4;
  localparam int DM_BIT  = 10;
  localparam int CNT_MAX = (1 << CNT_BIT) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run_req = 1'b0, step_req = 1'b0, pause_req = 1'b0, clr_cnt = 1'b0;
  logic [2:0]        probe_sel = 3'd0;
  logic [7:0]        probe_idx = 8'd0;
  logic              cpu_halt = 1'b0, cpu_is_jump = 1'b0, cpu_is_branch = 1'b0, cpu_branched = 1'b0;
  logic [31:0]       cpu_pc_dbg = '0, cpu_regfile_data_dbg = '0, cpu_datamem_data_dbg = '0, cpu_display = '0;
  logic              cpu_en;
  logic [4:0]        regfile_req_dbg;
  logic [DM_BIT-1:0] datamem_addr_dbg;
  logic [31:0]       probe_data;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  cpu_run_ctl #(.DmAddrBit(DM_BIT), .CntBit(CNT_BIT), .RunDiv(RUN_DIV)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .pause_req(pause_req),
    .clr_cnt(clr_cnt), .probe_sel(probe_sel), .probe_idx(probe_idx), .cpu_halt(cpu_halt),
    .cpu_is_jump(cpu_is_jump), .cpu_is_branch(cpu_is_branch), .cpu_branched(cpu_branched),
    .cpu_pc_dbg(cpu_pc_dbg), .cpu_regfile_data_dbg(cpu_regfile_data_dbg),
    .cpu_datamem_data_dbg(cpu_datamem_data_dbg), .cpu_display(cpu_display), .cpu_en(cpu_en),
    .regfile_req_dbg(regfile_req_dbg), .datamem_addr_dbg(datamem_addr_dbg),
    .probe_data(probe_data), .state_dbg(state_dbg));

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  idx;
    logic [31:0] display, pc, rf, dm;
    logic [31:0] exp_probe;
    logic [4:0]  exp_rf;
    logic [9:0]  exp_dm;
  } probe_vec_t;

  probe_vec_t  vecs[10];
  logic [31:0] sb_q[$];
  int          n_chk = 0, n_fail = 0, en_cnt = 0;
  int          m_state, m_div;
  int          m_cnt[4];
  logic        en_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_div   = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    sb_q.delete();
  endtask

  function automatic logic model_en();
    return !rst && !cpu_halt && ((m_state == 2) || ((m_state == 1) && (m_div == 0)));
  endfunction

  function automatic logic [31:0] model_probe();
    case (probe_sel)
      3'd0:    return cpu_display;
      3'd1:    return cpu_pc_dbg;
      3'd2:    return cpu_regfile_data_dbg;
      3'd3:    return cpu_datamem_data_dbg;
      default: return 32'(m_cnt[int'(probe_sel) - 4]);
    endcase
  endfunction

  task automatic model_update(input logic en);
    int nxt = m_state;
    for (int k = 0; k < 4; k++) begin
      logic inc;
      inc = en && ((k == 0) || ((k == 1) && cpu_is_jump) ||
                   ((k == 2) && cpu_is_branch) || ((k == 3) && cpu_branched));
      if (clr_cnt) m_cnt[k] = 0;
      else if (inc && (m_cnt[k] < CNT_MAX)) m_cnt[k]++;
    end
    case (m_state)
      0:       if (cpu_halt) nxt = 3; else if (run_req) nxt = 1; else if (step_req) nxt = 2;
      1:       if (cpu_halt) nxt = 3; else if (pause_req) nxt = 0;
      2:       nxt = cpu_halt ? 3 : 0;
      default: nxt = 3;
    endcase
    if ((m_state == 1) && (nxt == 1)) m_div = (m_div == RUN_DIV) ? 0 : m_div + 1;
    else m_div = 0;
    m_state = nxt;
  endtask

  // One clock: called at posedge+1 with inputs driven; checks mid-cycle, scoreboards probe_data.
  task automatic cyc();
    logic exp_en;
    #4;
    exp_en  = model_en();
    en_last = cpu_en;
    if (cpu_en === 1'b1) en_cnt++;
    check("cpu_en", 32'(cpu_en), 32'(exp_en));
    check("state_dbg", 32'(state_dbg), 32'(m_state));
    sb_q.push_back(model_probe());
    @(posedge clk);
    model_update(exp_en);
    #1;
    check("probe_data", probe_data, sb_q.pop_front());
    run_req = 1'b0; step_req = 1'b0; pause_req = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic probe_cnt(input logic [2:0] sel, input int exp, input string name);
    probe_sel = sel;
    cyc();
    check(name, probe_data, 32'(exp));
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h00, 32'hDEADBEEF, 32'h00400000, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 5'h00, 10'h000};
    vecs[1] = '{3'd1, 8'h3C, 32'h33333333, 32'h00400010, 32'h44444444, 32'h55555555, 32'h00400010, 5'h1C, 10'h03C};
    vecs[2] = '{3'd2, 8'h1F, 32'h66666666, 32'h00400020, 32'h12345678, 32'h77777777, 32'h12345678, 5'h1F, 10'h01F};
    vecs[3] = '{3'd2, 8'h1F, 32'h66666666, 32'h00400020, 32'hCAFEF00D, 32'h77777777, 32'hCAFEF00D, 5'h1F, 10'h01F};
    vecs[4] = '{3'd2, 8'hFF, 32'h88888888, 32'h00400030, 32'h0BADC0DE, 32'h99999999, 32'h0BADC0DE, 5'h1F, 10'h0FF};
    vecs[5] = '{3'd3, 8'h80, 32'hAAAAAAAA, 32'h00400040, 32'hBBBBBBBB, 32'hA5A55A5A, 32'hA5A55A5A, 5'h00, 10'h080};
    vecs[6] = '{3'd4, 8'h07, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000A, 5'h07, 10'h007};
    vecs[7] = '{3'd5, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'h00, 10'h000};
    vecs[8] = '{3'd6, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000A, 5'h00, 10'h000};
    vecs[9] = '{3'd7, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005, 5'h00, 10'h000};

    // Reset state
    #2;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_probe", probe_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Single step with a jump instruction
    cyc();
    step_req = 1'b1; cpu_is_jump = 1'b1; en_cnt = 0;
    repeat (3) cyc();
    cpu_is_jump = 1'b0;
    check("step_en_count", 32'(en_cnt), 32'd1);
    check("step_back_idle", 32'(state_dbg), 32'd0);
    probe_cnt(3'd4, 1, "step_inst_cnt");
    probe_cnt(3'd5, 1, "step_jump_cnt");

    // Divided free run: enable every 4th clk for 16 clks
    clr_cnt = 1'b1; cyc();
    run_req = 1'b1; cyc();
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) pause_req = 1'b1;
      cyc();
      check("run_en_phase", 32'(en_last), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    check("run_en_count", 32'(en_cnt), 32'd4);
    probe_cnt(3'd4, 4, "run_inst_cnt");
    check("pause_idle", 32'(state_dbg), 32'd0);
    check("pause_en_low", 32'(en_last), 32'd0);

    // Branch statistics: 10 retirements, taken on alternate ones
    clr_cnt = 1'b1; cyc();
    cpu_is_branch = 1'b1; cpu_branched = 1'b1; probe_sel = 3'd6;
    run_req = 1'b1; cyc();
    for (int i = 0; i < 40; i++) begin
      if (i == 39) pause_req = 1'b1;
      cyc();
      if (en_last === 1'b1) cpu_branched = ~cpu_branched;
    end
    cpu_is_branch = 1'b0; cpu_branched = 1'b0;
    probe_cnt(3'd6, 10, "br_branch_cnt");
    probe_cnt(3'd7, 5, "br_taken_cnt");
    probe_cnt(3'd4, 10, "br_inst_cnt");

    // Probe mux vectors (counters now inst=10 jump=0 branch=10 taken=5)
    for (int i = 0; i < 10; i++) begin
      probe_sel = vecs[i].sel; probe_idx = vecs[i].idx;
      cpu_display = vecs[i].display; cpu_pc_dbg = vecs[i].pc;
      cpu_regfile_data_dbg = vecs[i].rf; cpu_datamem_data_dbg = vecs[i].dm;
      #4;
      check("tbl_rf_req", 32'(regfile_req_dbg), 32'(vecs[i].exp_rf));
      check("tbl_dm_addr", 32'(datamem_addr_dbg), 32'(vecs[i].exp_dm));
      sb_q.push_back(vecs[i].exp_probe);
      @(posedge clk);
      model_update(1'b0);
      #1;
      check("tbl_probe", probe_data, sb_q.pop_front());
    end

    // Saturation: 20 steps on a 4-bit counter, then clear coincident with a step
    clr_cnt = 1'b1; cyc();
    repeat (20) begin
      step_req = 1'b1;
      cyc();
      cyc();
    end
    probe_cnt(3'd4, 15, "sat_inst_cnt");
    step_req = 1'b1; cyc();
    clr_cnt = 1'b1; cyc();
    check("clr_step_en", 32'(en_last), 32'd1);
    probe_cnt(3'd4, 0, "clr_prio_inst_cnt");

    // Halt during RUN on an enabled clk
    run_req = 1'b1; cyc();
    repeat (4) cyc();
    cpu_halt = 1'b1;
    cyc();
    check("halt_en_low", 32'(en_last), 32'd0);
    check("halt_state", 32'(state_dbg), 32'd3);
    en_cnt = 0;
    run_req = 1'b1; cyc();
    step_req = 1'b1; cyc();
    cpu_halt = 1'b0;
    step_req = 1'b1; cyc();
    run_req = 1'b1; cyc();
    check("halted_sticky", 32'(state_dbg), 32'd3);
    check("halted_no_en", 32'(en_cnt), 32'd0);

    // Reset leaves HALTED
    rst = 1'b1;
    #1;
    check("halt_exit_rst", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Asynchronous reset in the middle of RUN
    probe_sel = 3'd4;
    run_req = 1'b1; cyc();
    repeat (4) cyc();
    check("pre_rst_en", 32'(cpu_en), 32'd1);
    check("pre_rst_probe", probe_data, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(cpu_en), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_probe", probe_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    probe_cnt(3'd4, 0, "post_rst_inst_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
